cmplx_div_seq: RTL

Parametrised, multi-cycle signed fixed-point complex divider: Q = A/B = ((ac+bd) + (bc−ad)i)/(c²+d²), with A=a+bi and B=c+di.
- Generalises the single-cycle combinational complex divide in the ALU path.
- Adds a valid/ready handshake on both sides, a fractional-bit mode, a shared iterative divider, divide-by-zero detection and saturation.
- Sits in the ALU datapath alongside the other complex arithmetic units.

---
 rtl/cmplx_div_seq.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/cmplx_div_seq.sv
// Multi-cycle signed fixed-point complex divider Q = A/B using one shared restoring
// divider that produces a quotient bit of both components per cycle.
module cmplx_div_seq #(
    parameter int W    = 32,
    parameter int FRAC = 0
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] in_a,
    input  logic [2*W-1:0] in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_q,
    output logic           out_dz,
    output logic           out_sat,
    output logic           busy,
    output logic [2:0]     dbg_state
);

    // Handshake: a transfer happens on a clock edge where valid and ready are both
    // high; valid never drops and payload never changes until that edge.

    localparam int NB = 2*W + 1 + FRAC;
    localparam int DW = 2*W + 1;
    localparam int CW = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_DIV  = 3'd2,
        S_FIN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state_q;
    logic [2*W-1:0]  a_q, b_q;
    logic [NB-1:0]   nr_q, ni_q;
    logic [DW-1:0]   rr_q, ri_q;
    logic [DW-1:0]   den_q;
    logic            sr_q, si_q;
    logic [CW-1:0]   cnt_q;
    logic            in_ready_q, out_valid_q, busy_q, dz_q, sat_q;
    logic [2*W-1:0]  q_q;

    logic signed [2*W-1:0] ar, ai, br, bi;
    logic signed [2*W-1:0] p_ac, p_bd, p_bc, p_ad, p_cc, p_dd;
    logic [DW-1:0]   sum_r, sum_i, mag_r, mag_i, den_d;
    logic [NB-1:0]   num_r, num_i;

    logic [DW:0]     rsh_r, rsh_i, tr_r, tr_i;
    logic            qb_r, qb_i;
    logic [DW-1:0]   rr_d, ri_d;

    logic [W:0]      fin_r, fin_i;

    // Clamp a sign/magnitude quotient into W-bit two's complement; MSB of result is the clip flag.
    function automatic logic [W:0] sat_fn(input logic [NB-1:0] mag, input logic neg);
        logic [NB-1:0] lim;
        lim = NB'(1) << (W-1);
        if (neg) begin
            if (mag > lim) return {1'b1, 1'b1, {(W-1){1'b0}}};
            else           return {1'b0, W'(-mag)};
        end else begin
            if (mag >= lim) return {1'b1, 1'b0, {(W-1){1'b1}}};
            else            return {1'b0, W'(mag)};
        end
    endfunction

    always_comb begin
        ar = {{W{a_q[2*W-1]}}, a_q[2*W-1:W]};
        ai = {{W{a_q[W-1]}},   a_q[W-1:0]};
        br = {{W{b_q[2*W-1]}}, b_q[2*W-1:W]};
        bi = {{W{b_q[W-1]}},   b_q[W-1:0]};
        p_ac = ar * br;
        p_bd = ai * bi;
        p_bc = ai * br;
        p_ad = ar * bi;
        p_cc = br * br;
        p_dd = bi * bi;
        sum_r = {p_ac[2*W-1], p_ac} + {p_bd[2*W-1], p_bd};
        sum_i = {p_bc[2*W-1], p_bc} - {p_ad[2*W-1], p_ad};
        mag_r = sum_r[DW-1] ? -sum_r : sum_r;
        mag_i = sum_i[DW-1] ? -sum_i : sum_i;
        den_d = {1'b0, p_cc} + {1'b0, p_dd};
        num_r = NB'(mag_r) << FRAC;
        num_i = NB'(mag_i) << FRAC;
    end

    // One restoring step: the remainder stays below den_q, so DW+1 bits hold the trial.
    always_comb begin
        rsh_r = {rr_q, nr_q[NB-1]};
        rsh_i = {ri_q, ni_q[NB-1]};
        tr_r  = rsh_r - {1'b0, den_q};
        tr_i  = rsh_i - {1'b0, den_q};
        qb_r  = ~tr_r[DW];
        qb_i  = ~tr_i[DW];
        rr_d  = qb_r ? tr_r[DW-1:0] : rsh_r[DW-1:0];
        ri_d  = qb_i ? tr_i[DW-1:0] : rsh_i[DW-1:0];
        fin_r = sat_fn(nr_q, sr_q);
        fin_i = sat_fn(ni_q, si_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            nr_q        <= '0;
            ni_q        <= '0;
            rr_q        <= '0;
            ri_q        <= '0;
            den_q       <= '0;
            sr_q        <= 1'b0;
            si_q        <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            dz_q        <= 1'b0;
            sat_q       <= 1'b0;
            q_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= in_a;
                        b_q        <= in_b;
                        dz_q       <= 1'b0;
                        sat_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_PREP;
                    end
                end
                S_PREP: begin
                    nr_q  <= num_r;
                    ni_q  <= num_i;
                    sr_q  <= sum_r[DW-1];
                    si_q  <= sum_i[DW-1];
                    den_q <= den_d;
                    rr_q  <= '0;
                    ri_q  <= '0;
                    cnt_q <= '0;
                    if (den_d == '0) begin
                        q_q         <= '0;
                        dz_q        <= 1'b1;
                        sat_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    // Quotient bits enter at the LSB as the numerator drains out of the MSB.
                    nr_q  <= {nr_q[NB-2:0], qb_r};
                    ni_q  <= {ni_q[NB-2:0], qb_i};
                    rr_q  <= rr_d;
                    ri_q  <= ri_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(NB-1)) state_q <= S_FIN;
                end
                S_FIN: begin
                    q_q         <= {fin_r[W-1:0], fin_i[W-1:0]};
                    sat_q       <= fin_r[W] | fin_i[W];
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_q     = q_q;
    assign out_dz    = dz_q;
    assign out_sat   = sat_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
